// File: rtl/nn_pkg.sv
// Shared types and constants for the NN result collector.
// nn_decide turns one node's output pair into a class decision, winning score and margin.
package nn_pkg;
  localparam int DW    = 21;
  localparam int NODES = 4;
  localparam int FID_W = 8;

  typedef struct packed {
    logic [1:0]             node;
    logic                   cls;
    logic signed [DW-1:0]   score;
    logic [DW:0]            margin;
    logic [FID_W-1:0]       fid;
  } nn_result_t;

  function automatic nn_result_t nn_decide(input logic signed [DW-1:0] o0,
                                           input logic signed [DW-1:0] o1);
    nn_result_t       r;
    logic signed [DW:0] d;
    r        = '0;
    d        = {o0[DW-1], o0} - {o1[DW-1], o1};
    r.cls    = (o1 > o0);
    r.score  = r.cls ? o1 : o0;
    r.margin = d[DW] ? (~d + 1'b1) : d;
    return r;
  endfunction
endpackage

// File: rtl/nn_rr_arbiter.sv
// Round-robin arbiter over the pending nodes.
// The search starts at the pointer; on advance the pointer moves past the granted node.
module nn_rr_arbiter
  import nn_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [NODES-1:0] req_i,
  input  logic             advance_i,
  output logic [NODES-1:0] gnt_o,
  output logic [1:0]       idx_o,
  output logic             any_o
);
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] cand;
  logic       found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NODES; i++) begin
      cand = ptr_q + i[1:0];
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

  assign any_o = |req_i;
  assign ptr_d = advance_i ? (idx_o + 2'd1) : ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/nn_result_collector.sv
// Captures each node's output pair on a rising ready edge, buffers one result per node
// and drains them round-robin through a valid/ready stream with frame tracking.
module nn_result_collector
  import nn_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] out0_node0,
  input  logic signed [DW-1:0] out0_node1,
  input  logic signed [DW-1:0] out0_node2,
  input  logic signed [DW-1:0] out0_node3,
  input  logic signed [DW-1:0] out1_node0,
  input  logic signed [DW-1:0] out1_node1,
  input  logic signed [DW-1:0] out1_node2,
  input  logic signed [DW-1:0] out1_node3,
  input  logic                 out10_ready_node0,
  input  logic                 out10_ready_node1,
  input  logic                 out10_ready_node2,
  input  logic                 out10_ready_node3,
  input  logic                 out11_ready_node0,
  input  logic                 out11_ready_node1,
  input  logic                 out11_ready_node2,
  input  logic                 out11_ready_node3,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [1:0]           res_node,
  output logic                 res_class,
  output logic signed [DW-1:0] res_score,
  output logic [DW:0]          res_margin,
  output logic [FID_W-1:0]     res_fid,
  output logic                 frame_done,
  output logic [NODES-1:0]     overrun
);
  logic signed [DW-1:0] o0 [NODES];
  logic signed [DW-1:0] o1 [NODES];
  logic [NODES-1:0]     rdy;

  assign o0[0] = out0_node0;  assign o1[0] = out1_node0;
  assign o0[1] = out0_node1;  assign o1[1] = out1_node1;
  assign o0[2] = out0_node2;  assign o1[2] = out1_node2;
  assign o0[3] = out0_node3;  assign o1[3] = out1_node3;
  assign rdy = {out10_ready_node3 & out11_ready_node3, out10_ready_node2 & out11_ready_node2,
                out10_ready_node1 & out11_ready_node1, out10_ready_node0 & out11_ready_node0};

  logic [NODES-1:0] rdy_q, prev_q, pend_q, pend_d, ovr_q, ovr_d, emit_q, emit_d, emit_nxt;
  logic [NODES-1:0] cap, gnt, drain;
  logic [FID_W-1:0] fid_q, fid_d;
  logic             valid_q, valid_d, load, hs, any_pend;
  logic [1:0]       idx;
  nn_result_t       hold_q [NODES];
  nn_result_t       res_q, res_d;

  nn_rr_arbiter u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (pend_q),
    .advance_i (load),
    .gnt_o     (gnt),
    .idx_o     (idx),
    .any_o     (any_pend)
  );

  // ready levels pass through one register stage; edge detect compares it with the stage after
  assign cap   = rdy_q & ~prev_q;
  assign load  = (~valid_q | res_ready) & any_pend;
  assign drain = load ? gnt : '0;
  assign pend_d = cap | (pend_q & ~drain);
  assign ovr_d  = ovr_q | (cap & pend_q & ~drain);

  assign hs         = valid_q & res_ready;
  assign emit_nxt   = emit_q | ({{(NODES-1){1'b0}}, 1'b1} << res_q.node);
  assign frame_done = hs & (emit_nxt == {NODES{1'b1}});
  assign emit_d     = !hs ? emit_q : (frame_done ? '0 : emit_nxt);
  assign fid_d      = fid_q + FID_W'(frame_done);
  assign valid_d    = load | (valid_q & ~res_ready);

  always_comb begin
    res_d = res_q;
    if (load) begin
      res_d      = hold_q[idx];
      res_d.node = idx;
      res_d.fid  = fid_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q   <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
      ovr_q   <= '0;
      emit_q  <= '0;
      fid_q   <= '0;
      valid_q <= 1'b0;
      res_q   <= '0;
      for (int k = 0; k < NODES; k++) hold_q[k] <= '0;
    end else begin
      rdy_q   <= rdy;
      prev_q  <= rdy_q;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      emit_q  <= emit_d;
      fid_q   <= fid_d;
      valid_q <= valid_d;
      res_q   <= res_d;
      for (int k = 0; k < NODES; k++)
        if (cap[k]) hold_q[k] <= nn_decide(o0[k], o1[k]);
    end
  end

  assign res_valid  = valid_q;
  assign res_node   = res_q.node;
  assign res_class  = res_q.cls;
  assign res_score  = res_q.score;
  assign res_margin = res_q.margin;
  assign res_fid    = res_q.fid;
  assign overrun    = ovr_q;
endmodule
